// File: rtl/ddram_if.sv
// DDRAM Avalon-MM-style port bundle between a DDRAM initiator (master) and a responder (slave).
// Signal names match the DDRAM port so existing initiators map one-to-one.
interface ddram_if;
  // Handshake: a command (RD or WE) is taken on a rising edge where BUSY is low.
  // Write beats after the first need only WE. Read data is valid exactly in cycles with DOUT_READY high.
  logic        DDRAM_BUSY;
  logic [7:0]  DDRAM_BURSTCNT;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DOUT;
  logic        DDRAM_DOUT_READY;
  logic        DDRAM_RD;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic        DDRAM_WE;

  modport master (
    input  DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
    output DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
  );

  modport slave (
    output DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
    input  DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
  );
endinterface

// File: rtl/ddram_responder.sv
// Block-RAM backed stand-in for the HPS DDRAM port: windowed burst reads/writes with byte enables.
// Define DDRAM_RESP_STALL_EN to add LFSR-driven BUSY stalls in IDLE and gaps between read beats.
module ddram_responder #(
  parameter int         AW         = 12,
  parameter logic [5:0] BASE       = 6'b000111,
  parameter int         RD_LATENCY = 3
) (
  input  logic       DDRAM_CLK,
  input  logic       reset,
  ddram_if.slave     bus,
  output logic       err,
  output logic [1:0] dbg_state_o
);
  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BURST, WR_BURST} state_t;

  state_t        state_q;
  logic          busy_q;
  logic          ready_q;
  logic          err_q;
  logic [63:0]   dout_q;
  logic [AW-1:0] base_q;
  logic [7:0]    n_q;
  logic [7:0]    beat_q;
  logic          hit_q;
  logic [3:0]    wait_q;

  logic [63:0]   mem [0:(1<<AW)-1];

  logic          cmd_any;
  logic          cmd_hit;
  logic [7:0]    cmd_n;
  logic [AW-1:0] cmd_idx;
  logic [AW-1:0] cur_idx;
  logic          mem_we;
  logic [AW-1:0] mem_idx;
  logic          unused_addr;

`ifdef DDRAM_RESP_STALL_EN
  logic [15:0] lfsr_q;
  logic [1:0]  stall_q;
  logic [1:0]  gap_q;
  logic        lfsr_fb;
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
`endif

  assign cmd_any     = bus.DDRAM_RD | bus.DDRAM_WE;
  assign cmd_hit     = (bus.DDRAM_ADDR[28:23] == BASE);
  assign cmd_n       = (bus.DDRAM_BURSTCNT == 8'd0) ? 8'd1 : bus.DDRAM_BURSTCNT;
  assign cmd_idx     = bus.DDRAM_ADDR[AW-1:0];
  assign cur_idx     = base_q + AW'(beat_q);
  // Address bits between the RAM index and the window field alias onto the same words.
  assign unused_addr = ^bus.DDRAM_ADDR[22:AW];

  assign bus.DDRAM_BUSY       = busy_q;
  assign bus.DDRAM_DOUT_READY = ready_q;
  assign bus.DDRAM_DOUT       = dout_q;
  assign err                  = err_q;
  assign dbg_state_o          = state_q;

  always_comb begin
    mem_we  = 1'b0;
    mem_idx = cmd_idx;
    if (!reset && state_q == IDLE && !busy_q && bus.DDRAM_WE && cmd_hit) begin
      mem_we = 1'b1;
    end else if (!reset && state_q == WR_BURST && bus.DDRAM_WE && hit_q) begin
      mem_we  = 1'b1;
      mem_idx = cur_idx;
    end
  end

  always_ff @(posedge DDRAM_CLK) begin
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (bus.DDRAM_BE[b]) mem[mem_idx][8*b +: 8] <= bus.DDRAM_DIN[8*b +: 8];
      end
    end
  end

  always_ff @(posedge DDRAM_CLK) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
      base_q  <= '0;
      n_q     <= 8'd0;
      beat_q  <= 8'd0;
      hit_q   <= 1'b0;
      wait_q  <= 4'd0;
`ifdef DDRAM_RESP_STALL_EN
      lfsr_q  <= 16'hACE1;
      stall_q <= 2'd0;
      gap_q   <= 2'd0;
`endif
    end else begin
      ready_q <= 1'b0;
`ifdef DDRAM_RESP_STALL_EN
      lfsr_q  <= {lfsr_q[14:0], lfsr_fb};
`endif
      unique case (state_q)
        IDLE: begin
          if (busy_q) begin
            if (cmd_any) err_q <= 1'b1;
`ifdef DDRAM_RESP_STALL_EN
            stall_q <= stall_q - 2'd1;
            if (stall_q == 2'd1) busy_q <= 1'b0;
`else
            busy_q <= 1'b0;
`endif
          end else if (bus.DDRAM_WE) begin
            // A simultaneous read is dropped; the write proceeds.
            if (bus.DDRAM_RD) err_q <= 1'b1;
            base_q <= cmd_idx;
            n_q    <= cmd_n;
            hit_q  <= cmd_hit;
            beat_q <= 8'd1;
            if (cmd_n != 8'd1) state_q <= WR_BURST;
          end else if (bus.DDRAM_RD) begin
            base_q  <= cmd_idx;
            n_q     <= cmd_n;
            hit_q   <= cmd_hit;
            beat_q  <= 8'd0;
            wait_q  <= 4'(RD_LATENCY - 2);
            busy_q  <= 1'b1;
            state_q <= RD_WAIT;
          end
`ifdef DDRAM_RESP_STALL_EN
          else if (lfsr_q[1:0] == 2'b00) begin
            busy_q  <= 1'b1;
            stall_q <= (lfsr_q[3:2] == 2'b00) ? 2'd1 : lfsr_q[3:2];
          end
`endif
        end
        RD_WAIT: begin
          if (cmd_any) err_q <= 1'b1;
          if (wait_q == 4'd0) begin
            ready_q <= 1'b1;
            dout_q  <= hit_q ? mem[cur_idx] : 64'd0;
            beat_q  <= beat_q + 8'd1;
            state_q <= RD_BURST;
`ifdef DDRAM_RESP_STALL_EN
            gap_q   <= 2'd0;
`endif
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        RD_BURST: begin
          if (cmd_any) err_q <= 1'b1;
          if (beat_q == n_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
`ifdef DDRAM_RESP_STALL_EN
          else if (gap_q != 2'd0) begin
            gap_q <= gap_q - 2'd1;
          end
`endif
          else begin
            ready_q <= 1'b1;
            dout_q  <= hit_q ? mem[cur_idx] : 64'd0;
            beat_q  <= beat_q + 8'd1;
`ifdef DDRAM_RESP_STALL_EN
            gap_q   <= (lfsr_q[5:4] == 2'b11) ? 2'd0 : lfsr_q[5:4];
`endif
          end
        end
        WR_BURST: begin
          if (bus.DDRAM_RD) err_q <= 1'b1;
          if (bus.DDRAM_WE) begin
            beat_q <= beat_q + 8'd1;
            if (beat_q == n_q - 8'd1) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
